// File: rtl/turbo_pkg.sv
// Shared state type and sizing helpers for the turbo block serializer.
// Pure declarations: no timing, no flow control.
package turbo_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } ser_state_t;

  function automatic int nstreams(input int nout);
    return 1 + 2 * nout;
  endfunction

  // Beats per block when data positions carry one alternating parity bit.
  function automatic int punctured_beats(input int n, input int tail_bits, input int nout);
    return 2 * n + nstreams(nout) * tail_bits;
  endfunction

endpackage

// File: rtl/turbo_serial_index_gen.sv
// Walks (pos, stream) position-major over one block; TURBO_SERIALIZER_PUNCTURE_EN skips unused parity.
// Index and last come straight from registers; counters move only on advance (an accepted beat).
module turbo_serial_index_gen import turbo_pkg::*; #(
  parameter  int N         = 10,
  parameter  int TAIL_BITS = 2,
  parameter  int NOUT      = 2,
  localparam int NSTREAM   = nstreams(NOUT),
  localparam int L         = N + TAIL_BITS,
  localparam int SW        = $clog2(NSTREAM),
  localparam int PW        = $clog2(L)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          advance,
  output logic [PW-1:0] pos,
  output logic [SW-1:0] stream,
  output logic          last
);

  localparam logic [SW-1:0] LAST_STREAM = SW'(NSTREAM - 1);
  localparam logic [PW-1:0] LAST_POS    = PW'(L - 1);
`ifdef TURBO_SERIALIZER_PUNCTURE_EN
  localparam logic [PW-1:0] DATA_END    = PW'(N);
  localparam logic [SW-1:0] ENC1_STREAM = SW'(1);
  localparam logic [SW-1:0] ENC2_STREAM = SW'(NOUT + 1);
`endif

  logic [PW-1:0] pos_q;
  logic [PW-1:0] pos_d;
  logic [SW-1:0] stream_q;
  logic [SW-1:0] stream_d;

  always_comb begin
    pos_d    = pos_q;
    stream_d = stream_q;
    if (stream_q == LAST_STREAM) begin
      stream_d = '0;
      pos_d    = (pos_q == LAST_POS) ? '0 : pos_q + 1'b1;
    end else begin
      stream_d = stream_q + 1'b1;
    end
`ifdef TURBO_SERIALIZER_PUNCTURE_EN
    // Data positions: systematic, then encoder-1 on even pos or encoder-2 on odd pos.
    if (pos_q < DATA_END) begin
      if (stream_q == '0) begin
        pos_d    = pos_q;
        stream_d = pos_q[0] ? ENC2_STREAM : ENC1_STREAM;
      end else begin
        pos_d    = pos_q + 1'b1;
        stream_d = '0;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      pos_q    <= '0;
      stream_q <= '0;
    end else if (advance) begin
      pos_q    <= pos_d;
      stream_q <= stream_d;
    end
  end

  assign pos    = pos_q;
  assign stream = stream_q;
  assign last   = (pos_q == LAST_POS) && (stream_q == LAST_STREAM);

endmodule

// File: rtl/turbo_block_serializer.sv
// Captures a parallel turbo block and streams it one bit per beat, first beat the cycle after capture; TURBO_SERIALIZER_PUNCTURE_EN enables parity puncturing.
// out_* hold while out_ready is low; in_ready only in IDLE, so blocks are separated by one idle cycle.
module turbo_block_serializer import turbo_pkg::*; #(
  parameter  int N         = 10,
  parameter  int TAIL_BITS = 2,
  parameter  int NOUT      = 2,
  localparam int NSTREAM   = nstreams(NOUT),
  localparam int L         = N + TAIL_BITS,
  localparam int SW        = $clog2(NSTREAM),
  localparam int PW        = $clog2(L)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          y [NSTREAM][L],
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_bit,
  output logic [SW-1:0] out_stream,
  output logic [PW-1:0] out_pos,
  output logic          out_last
);

  ser_state_t    state_q;
  ser_state_t    state_d;
  logic          blk_buf [NSTREAM][L];
  logic          capture;
  logic          beat_acc;
  logic          idx_last;
  logic [SW-1:0] idx_stream;
  logic [PW-1:0] idx_pos;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Gating with reset keeps a beat from looking accepted in the cycle it is aborted.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    capture   = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = !reset;
        capture  = in_valid && !reset;
        if (capture) state_d = SEND;
      end
      SEND: begin
        out_valid = !reset;
        if (out_ready && idx_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign beat_acc = out_valid && out_ready;

  always_ff @(posedge clk) begin
    for (int s = 0; s < NSTREAM; s++) begin
      for (int p = 0; p < L; p++) begin
        if (reset) begin
          blk_buf[s][p] <= 1'b0;
        end else if (capture) begin
          blk_buf[s][p] <= y[s][p];
        end
      end
    end
  end

  turbo_serial_index_gen #(
    .N         (N),
    .TAIL_BITS (TAIL_BITS),
    .NOUT      (NOUT)
  ) u_index_gen (
    .clk     (clk),
    .reset   (reset),
    .clear   (capture),
    .advance (beat_acc),
    .pos     (idx_pos),
    .stream  (idx_stream),
    .last    (idx_last)
  );

  assign out_bit    = out_valid && blk_buf[idx_stream][idx_pos];
  assign out_stream = idx_stream;
  assign out_pos    = idx_pos;
  assign out_last   = out_valid && idx_last;

endmodule

// File: tb/tb_turbo_block_serializer.sv
// Directed bench for turbo_block_serializer: queue-based order model plus hand-computed pins.
module tb_turbo_block_serializer;

  localparam int N         = 10;
  localparam int TAIL_BITS = 2;
  localparam int NOUT      = 2;
  localparam int NSTREAM   = 1 + 2 * NOUT;
  localparam int L         = N + TAIL_BITS;
`ifdef TURBO_SERIALIZER_PUNCTURE_EN
  localparam int BEATS = 30;
  localparam bit PUNC  = 1'b1;
`else
  localparam int BEATS = 60;
  localparam bit PUNC  = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       y [NSTREAM][L];
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic       out_bit;
  logic [2:0] out_stream;
  logic [3:0] out_pos;
  logic       out_last;

  always #5 clk = ~clk;

  turbo_block_serializer dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .y          (y),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_bit    (out_bit),
    .out_stream (out_stream),
    .out_pos    (out_pos),
    .out_last   (out_last)
  );

  typedef struct {
    int s;
    int p;
    int b;
    int last;
    int cyc;
  } beat_t;

  beat_t exp_q[$];
  beat_t obs_q[$];
  int    checks = 0;
  int    failures = 0;
  int    cyc = 0;
  int    hold_cnt = 0;
  bit    exp_valid = 1'b0;
  bit    tog = 1'b0;

  logic       prev_hold = 1'b0;
  logic       prev_bit, prev_last;
  logic [2:0] prev_stream;
  logic [3:0] prev_pos;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Expected beat order from the block currently on y.
  function automatic void push_block();
    for (int p = 0; p < L; p++) begin
      for (int s = 0; s < NSTREAM; s++) begin
        beat_t b;
        if (PUNC && p < N && s != 0 && s != ((p % 2 == 0) ? 1 : NOUT + 1)) continue;
        b.s    = s;
        b.p    = p;
        b.b    = int'(y[s][p]);
        b.last = int'(p == L - 1 && s == NSTREAM - 1);
        b.cyc  = 0;
        exp_q.push_back(b);
      end
    end
  endfunction

  function automatic void fill(input int kind);
    for (int s = 0; s < NSTREAM; s++)
      for (int t = 0; t < L; t++)
        case (kind)
          0:       y[s][t] = 1'((s + t) % 2);
          1:       y[s][t] = 1'b1;
          default: y[s][t] = 1'((s + t + 1) % 2);
        endcase
  endfunction

  function automatic int ones_seen();
    int n = 0;
    foreach (obs_q[i]) n += obs_q[i].b;
    return n;
  endfunction

  always @(negedge clk) begin
    beat_t e;
    cyc++;
    if (reset) begin
      exp_q.delete();
      exp_valid = 1'b0;
    end else begin
      chk("out_valid", 32'(out_valid), 32'(exp_valid));
      chk("in_ready", 32'(in_ready), 32'(!exp_valid));
      if (prev_hold) begin
        hold_cnt++;
        chk("hold_valid", 32'(out_valid), 1);
        chk("hold_bit", 32'(out_bit), 32'(prev_bit));
        chk("hold_stream", 32'(out_stream), 32'(prev_stream));
        chk("hold_pos", 32'(out_pos), 32'(prev_pos));
        chk("hold_last", 32'(out_last), 32'(prev_last));
      end
      if (out_valid && out_ready) begin
        chk("beat_expected", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("beat_stream", 32'(out_stream), e.s);
          chk("beat_pos", 32'(out_pos), e.p);
          chk("beat_bit", 32'(out_bit), e.b);
          chk("beat_last", 32'(out_last), e.last);
          e.cyc = cyc;
          obs_q.push_back(e);
          if (e.last != 0) exp_valid = 1'b0;
        end
      end
      if (in_valid && in_ready) begin
        push_block();
        exp_valid = 1'b1;
      end
    end
    prev_hold   = out_valid && !out_ready && !reset;
    prev_bit    = out_bit;
    prev_stream = out_stream;
    prev_pos    = out_pos;
    prev_last   = out_last;
  end

  initial forever begin
    @(posedge clk);
    #2;
    if (tog) out_ready = ~out_ready;
  end

  task automatic start_block();
    @(posedge clk);
    #1 in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_ready(input int max, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < max);
    chk("wait_ready_bound", 32'(in_ready), 1);
  endtask

  initial begin
    int n;
    fill(0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_last", 32'(out_last), 0);
    chk("rst_out_bit", 32'(out_bit), 0);
    chk("rst_out_stream", 32'(out_stream), 0);
    chk("rst_out_pos", 32'(out_pos), 0);
    @(posedge clk);
    #1 reset = 1'b0;

    // Pattern block, out_ready held high.
    obs_q.delete();
    start_block();
    wait_ready(400, n);
    chk("t1_ready_cycle", n, BEATS + 1);
    chk("t1_beats", obs_q.size(), BEATS);
`ifdef TURBO_SERIALIZER_PUNCTURE_EN
    chk("t1_s0", obs_q[0].s, 0);
    chk("t1_s1", obs_q[1].s, 1);
    chk("t1_s2", obs_q[2].s, 0);
    chk("t1_s3", obs_q[3].s, 3);
    chk("t1_p3", obs_q[3].p, 1);
    chk("t1_b3", obs_q[3].b, 0);
    chk("t1_s20", obs_q[20].s, 0);
    chk("t1_p20", obs_q[20].p, 10);
    chk("t1_s24", obs_q[24].s, 4);
    chk("t1_p29", obs_q[29].p, 11);
    chk("t1_last29", obs_q[29].last, 1);
`else
    chk("t1_s7", obs_q[7].s, 2);
    chk("t1_p7", obs_q[7].p, 1);
    chk("t1_b7", obs_q[7].b, 1);
    chk("t1_last58", obs_q[58].last, 0);
    chk("t1_last59", obs_q[59].last, 1);
    chk("t1_p59", obs_q[59].p, 11);
`endif

    // Same block with out_ready toggling.
    obs_q.delete();
    hold_cnt = 0;
    tog = 1'b1;
    start_block();
    wait_ready(800, n);
    @(posedge clk);
    #1 tog = 1'b0;
    out_ready = 1'b1;
    chk("t2_beats", obs_q.size(), BEATS);
    chk("t2_holds_seen", 32'(hold_cnt >= BEATS - 1), 1);

    // Second in_valid mid-SEND is ignored; later all-ones block is captured.
    obs_q.delete();
    start_block();
    repeat (10) @(posedge clk);
    #1 fill(1);
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    wait_ready(400, n);
    chk("t3_beats", obs_q.size(), BEATS);
    chk("t3_pattern_ones", ones_seen(), BEATS / 2);
    obs_q.delete();
    start_block();
    wait_ready(400, n);
    chk("t3_ones_beats", obs_q.size(), BEATS);
    chk("t3_all_ones", ones_seen(), BEATS);

    // Reset at beat 17 aborts the block.
    fill(0);
    obs_q.delete();
    start_block();
    repeat (17) @(posedge clk);
    chk("t4_beats_before_reset", obs_q.size(), 17);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("t4_out_valid_after", 32'(out_valid), 0);
    chk("t4_in_ready_after", 32'(in_ready), 1);
    obs_q.delete();
    start_block();
    wait_ready(400, n);
    chk("t4_new_beats", obs_q.size(), BEATS);
    chk("t4_first_stream", obs_q[0].s, 0);
    chk("t4_first_pos", obs_q[0].p, 0);

    // Back-to-back with in_valid held high.
    obs_q.delete();
    fill(0);
    @(posedge clk);
    #1 in_valid = 1'b1;
    @(posedge clk);
    #1 fill(2);
    wait_ready(400, n);
    @(posedge clk);
    #1 in_valid = 1'b0;
    wait_ready(400, n);
    chk("t5_beats", obs_q.size(), 2 * BEATS);
    chk("t5_a_last", obs_q[BEATS - 1].last, 1);
    chk("t5_gap", obs_q[BEATS].cyc - obs_q[BEATS - 1].cyc, 2);
    chk("t5_b_first_bit", obs_q[BEATS].b, 1);
    chk("t5_b_first_pos", obs_q[BEATS].p, 0);

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
